// File: rtl/prover_compute_v_srunload_pkg.sv
// Shared types for the compute_v serial unload drain.
// Element width falls back to 16 bits when the field arithmetic defines are not loaded.
`ifndef F_NBITS
`define F_NBITS 16
`endif

package prover_compute_v_srunload_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/prover_compute_v_srunload_srelem.sv
// One slot of the unload chain: parallel load, or shift by one or two positions.
module prover_compute_v_srelem #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en,
  input  logic         load,
  input  logic         bypass,
  input  logic [W-1:0] in_normal,
  input  logic [W-1:0] in_bypass,
  input  logic [W-1:0] in_load,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)    q <= '0;
    else if (en)  q <= load ? in_load : (bypass ? in_bypass : in_normal);
  end
endmodule

// File: rtl/prover_compute_v_srunload.sv
// Parallel-in / serial-out drain for compute_v: load a vector, emit slot 0 each beat.
module prover_compute_v_srunload
  import prover_compute_v_srunload_pkg::*;
#(
  parameter int NELMS    = 8,
  parameter int CNT_BITS = $clog2(NELMS + 1)
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NELMS*`F_NBITS-1:0] in_data,
  input  logic [CNT_BITS-1:0]       in_count,
  input  logic                      in_stride2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`F_NBITS-1:0]       out_data,
  output logic                      out_last,
  input  logic                      flush,
  output logic                      busy
);
  localparam int W    = `F_NBITS;
  localparam int HALF = (NELMS + 1) / 2;

  logic [NELMS-1:0][W-1:0] slot;
  state_t                  state, state_nxt;
  logic [CNT_BITS-1:0]     remaining, remaining_nxt, eff_count, cap;
  logic                    stride2, stride2_nxt;
  logic                    load_fire, shift_fire, slot_en;

  // Stride-2 can never emit more than the even-indexed half of the chain.
  always_comb begin
    cap       = in_stride2 ? CNT_BITS'(HALF) : CNT_BITS'(NELMS);
    eff_count = (in_count > cap) ? cap : in_count;
  end

  assign slot_en = load_fire | shift_fire;

  for (genvar i = 0; i < NELMS; i++) begin : g_slot
    logic [W-1:0] nrm, byp;
    if (i + 1 < NELMS) begin : g_n
      assign nrm = slot[i+1];
    end else begin : g_nz
      assign nrm = '0;
    end
    if (i + 2 < NELMS) begin : g_b
      assign byp = slot[i+2];
    end else begin : g_bz
      assign byp = '0;
    end
    prover_compute_v_srelem #(.W(W)) u_elem (
      .clk       (clk),
      .rstb      (rstb),
      .en        (slot_en),
      .load      (load_fire),
      .bypass    (stride2),
      .in_normal (nrm),
      .in_bypass (byp),
      .in_load   (in_data[i*W +: W]),
      .q         (slot[i])
    );
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      remaining <= '0;
      stride2   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      stride2   <= stride2_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    stride2_nxt   = stride2;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    load_fire     = 1'b0;
    shift_fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ~flush;
        if (in_valid && !flush) begin
          load_fire     = 1'b1;
          stride2_nxt   = in_stride2;
          remaining_nxt = eff_count;
          if (eff_count != '0) state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_valid = 1'b1;
        out_last  = (remaining == CNT_BITS'(1));
        if (out_ready && !flush) begin
          shift_fire    = 1'b1;
          remaining_nxt = remaining - CNT_BITS'(1);
          if (out_last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Flush wins over any handshake seen in the same cycle; slots keep their contents.
    if (flush) begin
      state_nxt     = ST_IDLE;
      remaining_nxt = '0;
    end
  end

  assign out_data = out_valid ? slot[0] : '0;
  assign busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_prover_compute_v_srunload.sv
// Scoreboard bench for the compute_v serial unload drain.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module tb_prover_compute_v_srunload;
  localparam int NELMS = 8;
  localparam int CB    = $clog2(NELMS + 1);
  localparam int W     = `F_NBITS;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NELMS*W-1:0]   in_data = '0;
  logic [CB-1:0]        in_count = '0;
  logic                 in_stride2 = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [W-1:0]         out_data;
  logic                 out_last;
  logic                 flush = 1'b0;
  logic                 busy;

  typedef struct { logic [W-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  prover_compute_v_srunload #(.NELMS(NELMS)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_count(in_count), .in_stride2(in_stride2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NELMS*W-1:0] mk_vec(input int base, input int n);
    logic [NELMS*W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  // Drives one load cycle and pushes the beats the drain should emit.
  task automatic load_vec(input logic [NELMS*W-1:0] d, input int cnt, input logic s2);
    int eff, step;
    exp_t e;
    in_valid = 1'b1; in_data = d; in_count = CB'(cnt); in_stride2 = s2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready: in_ready=%b expected 1", in_ready);
    end
    eff  = s2 ? ((cnt > 4) ? 4 : cnt) : ((cnt > 8) ? 8 : cnt);
    step = s2 ? 2 : 1;
    for (int j = 0; j < eff; j++) begin
      e.d = d[j*step*W +: W];
      e.l = (j == eff - 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Runs cycles with out_ready from pat until max_beats are accepted or the scoreboard empties.
  task automatic drain(input string nm, input int max_beats, input logic [31:0] pat, input int budget);
    int beats, c;
    beats = 0; c = 0;
    while (beats < max_beats && sb.size() > 0 && c < budget) begin
      out_ready = pat[c % 32];
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL %s_valid: cycle %0d out_valid=%b expected 1", nm, c, out_valid);
      end else begin
        checks++;
        if (out_data !== sb[0].d || out_last !== sb[0].l) begin
          errors++;
          $display("FAIL %s_data: cycle %0d data=%0d last=%b expected data=%0d last=%b",
                   nm, c, out_data, out_last, sb[0].d, sb[0].l);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          beats++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    if (c >= budget) begin
      errors++; $display("FAIL %s_timeout: %0d beats left expected 0", nm, sb.size());
    end
  endtask

  task automatic expect_idle(input string nm);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%b in_ready=%b busy=%b expected 0 1 0", nm, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (out_valid !== 0 || out_last !== 0 || out_data !== '0 || busy !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset: v=%b l=%b d=%0d busy=%b rdy=%b expected 0 0 0 0 1", out_valid, out_last, out_data, busy, in_ready);
    end
    rstb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    load_vec(mk_vec(1, 8), 8, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_latency: v=%b rdy=%b busy=%b expected 1 0 1", out_valid, in_ready, busy);
    end
    drain("basic", 8, 32'hFFFF_FFFF, 20);
    expect_idle("basic");
  endtask

  task automatic test_stride2;
    load_vec(mk_vec(1, 8), 7, 1'b1);
    drain("stride2", 8, 32'hFFFF_FFFF, 20);
    expect_idle("stride2");
  endtask

  task automatic test_backpressure;
    load_vec(mk_vec(1, 8), 3, 1'b0);
    drain("bp", 3, 32'hFFFF_FFF9, 20);
    expect_idle("bp");
  endtask

  task automatic test_zero_over;
    load_vec(mk_vec(1, 8), 0, 1'b0);
    expect_idle("zero");
    @(posedge clk);
    expect_idle("zero2");
    load_vec(mk_vec(11, 8), 15, 1'b0);
    drain("over", 16, 32'hFFFF_FFFF, 20);
    expect_idle("over");
  endtask

  task automatic test_flush;
    load_vec(mk_vec(1, 8), 8, 1'b0);
    drain("flush_pre", 2, 32'hFFFF_FFFF, 20);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    expect_idle("flush");
    load_vec(mk_vec(9, 2), 2, 1'b0);
    drain("flush_post", 8, 32'hFFFF_FFFF, 20);
    expect_idle("flush_post");
    // Load presented together with flush in IDLE must be dropped.
    in_valid = 1'b1; flush = 1'b1; in_count = CB'(3);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: in_ready=%b expected 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    expect_idle("flush_drop");
  endtask

  task automatic test_async_reset;
    load_vec(mk_vec(21, 8), 8, 1'b0);
    drain("arst_pre", 3, 32'hFFFF_FFFF, 20);
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || busy !== 0 || out_data !== '0) begin
      errors++; $display("FAIL arst: v=%b rdy=%b busy=%b d=%0d expected 0 1 0 0", out_valid, in_ready, busy, out_data);
    end
    sb.delete();
    #3 rstb = 1'b1;
    @(posedge clk); #1;
    expect_idle("arst_rel");
    load_vec(mk_vec(31, 8), 5, 1'b0);
    drain("arst_post", 8, 32'hFFFF_FFFF, 20);
    expect_idle("arst_post");
  endtask

  task automatic test_back_to_back;
    load_vec(mk_vec(41, 8), 2, 1'b1);
    drain("b2b_a", 8, 32'hFFFF_FFFF, 20);
    load_vec(mk_vec(51, 8), 1, 1'b0);
    drain("b2b_b", 8, 32'hFFFF_FFFF, 20);
    expect_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_backpressure();
    test_zero_over();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
